// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg
//   Shared width-derivation helpers for the banked RAM: bank-select width,
//   in-bank index width and busy-counter width, all clog2-based with a floor
//   of one bit so degenerate parameter choices still give legal vectors.
package banked_ram_pkg;

  // Width of the bank-select field (addr mod BANKS).
  function automatic int bank_bits(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Width of the in-bank word index (addr / BANKS).
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a bank busy counter; it must hold max(READ, WRITE latency) - 1.
  function automatic int cnt_bits(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank
//   One bank of the banked RAM: word array with byte-masked write, an
//   asynchronous read port (sampled by the parent on the accept edge) and a
//   busy counter that blocks further accepts while it is non-zero.
//   The array itself is never reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset (counter only)
//   rd_acc, wr_acc  this bank accepts a read / write on this edge
//   idx             in-bank word index
//   din, mask       write data and byte enables
//   rdata           array word at idx (combinational)
//   idle            busy counter is zero
module ram_bank
  import banked_ram_pkg::*;
#(
  parameter int WORD_WIDTH    = 64,
  parameter int DEPTH         = 16384,
  parameter int READ_LATENCY  = 100,
  parameter int WRITE_LATENCY = 100,
  parameter int IDX_W         = idx_bits(DEPTH),
  parameter int CNT_W         = cnt_bits(READ_LATENCY, WRITE_LATENCY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_acc,
  input  logic                    wr_acc,
  input  logic [IDX_W-1:0]        idx,
  input  logic [WORD_WIDTH-1:0]   din,
  input  logic [WORD_WIDTH/8-1:0] mask,
  output logic [WORD_WIDTH-1:0]   rdata,
  output logic                    idle
);

  localparam int BYTES = WORD_WIDTH / 8;

  logic [WORD_WIDTH-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]      cnt_r;

  // Byte-masked array write on a write accept; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask[b]) begin
          mem_r[idx][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
    end
  end

  // Busy counter: loaded with latency-1 on accept, counts down to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (rd_acc) begin
      cnt_r <= CNT_W'(READ_LATENCY - 1);
    end else if (wr_acc) begin
      cnt_r <= CNT_W'(WRITE_LATENCY - 1);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rdata = mem_r[idx];
  assign idle  = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/banked_ram.sv
// banked_ram
//   Word-addressed RAM split into BANKS interleaved banks (bank = addr mod
//   BANKS, index = addr / BANKS). Each bank blocks new accepts for a fixed
//   number of cycles after a read or write; different banks can be hit on
//   back-to-back cycles. Read data returns in accept order through a
//   READ_LATENCY-deep valid/data pipeline. Addresses >= SIZE are answered
//   with a one-cycle err strobe and never touch a bank.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   addr       word address
//   din, mask  write data, byte write enables
//   re, we     read / write request (read wins when both are set)
//   ready      combinational: a request on addr would be accepted now
//   dout       read data, held between strobes
//   dvalid     one-cycle read-data strobe
//   err        one-cycle out-of-range strobe
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int SIZE          = 65536,
  parameter int ADDR_WIDTH    = 64,
  parameter int WORD_WIDTH    = 64,
  parameter int BANKS         = 4,
  parameter int READ_LATENCY  = 100,
  parameter int WRITE_LATENCY = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_WIDTH-1:0]   din,
  input  logic [WORD_WIDTH/8-1:0] mask,
  input  logic                    re,
  input  logic                    we,
  output logic                    ready,
  output logic [WORD_WIDTH-1:0]   dout,
  output logic                    dvalid,
  output logic                    err
);

  localparam int DEPTH  = SIZE / BANKS;
  localparam int BANK_W = bank_bits(BANKS);
  localparam int IDX_W  = idx_bits(DEPTH);
  localparam int CNT_W  = cnt_bits(READ_LATENCY, WRITE_LATENCY);

  logic [BANK_W-1:0]     bank_sel_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  oor_s;
  logic                  ready_s;
  logic                  req_s;
  logic                  acc_s;
  logic                  rd_any_s;
  logic [BANKS-1:0]      rd_acc_s;
  logic [BANKS-1:0]      wr_acc_s;
  logic [BANKS-1:0]      bank_idle_s;
  logic [WORD_WIDTH-1:0] bank_rdata_s [BANKS];
  logic [WORD_WIDTH-1:0] rdata_s;
  logic                  tail_v_s;
  logic [WORD_WIDTH-1:0] tail_d_s;
  logic                  dvalid_r;
  logic                  err_r;
  logic [WORD_WIDTH-1:0] dout_r;

  // Address decode, acceptance and per-bank strobes.
  always_comb begin
    bank_sel_s = BANK_W'(addr % ADDR_WIDTH'(BANKS));
    idx_s      = IDX_W'(addr / ADDR_WIDTH'(BANKS));
    oor_s      = (addr >= ADDR_WIDTH'(SIZE));
    // Out-of-range requests are always "accepted" so they can be errored.
    ready_s    = oor_s | bank_idle_s[bank_sel_s];
    req_s      = (re | we) & ~rst;
    acc_s      = req_s & ready_s & ~oor_s;
    rd_any_s   = acc_s & re;
    rdata_s    = bank_rdata_s[bank_sel_s];
    rd_acc_s   = '0;
    wr_acc_s   = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_sel_s == BANK_W'(b)) begin
        rd_acc_s[b] = acc_s & re;
        wr_acc_s[b] = acc_s & we & ~re;
      end else begin
        rd_acc_s[b] = 1'b0;
        wr_acc_s[b] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    ram_bank #(
      .WORD_WIDTH    (WORD_WIDTH),
      .DEPTH         (DEPTH),
      .READ_LATENCY  (READ_LATENCY),
      .WRITE_LATENCY (WRITE_LATENCY),
      .IDX_W         (IDX_W),
      .CNT_W         (CNT_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .rd_acc (rd_acc_s[g]),
      .wr_acc (wr_acc_s[g]),
      .idx    (idx_s),
      .din    (din),
      .mask   (mask),
      .rdata  (bank_rdata_s[g]),
      .idle   (bank_idle_s[g])
    );
  end

  // The final latency stage is the output register itself, so the internal
  // pipeline is READ_LATENCY-1 deep and vanishes for a latency of one.
  if (READ_LATENCY > 1) begin : g_pipe
    logic [READ_LATENCY-2:0] v_r;
    logic [WORD_WIDTH-1:0]   d_r [READ_LATENCY-1];

    // Response shift register; reset drops any reads still in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < READ_LATENCY - 1; k++) begin
          v_r[k] <= 1'b0;
          d_r[k] <= {WORD_WIDTH{1'b0}};
        end
      end else begin
        v_r[0] <= rd_any_s;
        d_r[0] <= rdata_s;
        for (int k = 1; k < READ_LATENCY - 1; k++) begin
          v_r[k] <= v_r[k-1];
          d_r[k] <= d_r[k-1];
        end
      end
    end

    assign tail_v_s = v_r[READ_LATENCY-2];
    assign tail_d_s = d_r[READ_LATENCY-2];
  end else begin : g_nopipe
    assign tail_v_s = rd_any_s;
    assign tail_d_s = rdata_s;
  end

  // Output registers; dout only moves when a response lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid_r <= 1'b0;
      err_r    <= 1'b0;
      dout_r   <= {WORD_WIDTH{1'b0}};
    end else begin
      dvalid_r <= tail_v_s;
      err_r    <= req_s & oor_s;
      if (tail_v_s) begin
        dout_r <= tail_d_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign ready  = ready_s;
  assign dvalid = dvalid_r;
  assign err    = err_r;
  assign dout   = dout_r;

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 SIZE, 65536, total capacity in words.
REQ-002 ADDR_WIDTH, 64, address width in bits.
REQ-003 WORD_WIDTH, 64, word width in bits; a multiple of 8.
REQ-004 BANKS, 4, number of independent banks; power of two, at least 1.
REQ-005 READ_LATENCY, 100, cycles from read accept to data; at least 1.
REQ-006 WRITE_LATENCY, 100, cycles a bank stays busy after a write accept; at least 1.
REQ-007 Reset rst SHALL be synchronous, active-high; clock clk.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 addr  in  ADDR_WIDTH  word address.
REQ-011 din  in  WORD_WIDTH  write data.
REQ-012 mask  in  WORD_WIDTH/8  byte write enables.
REQ-013 re  in  1  read request.
REQ-014 we  in  1  write request.
REQ-015 ready  out  1  combinational; the request on addr is accepted this cycle.
REQ-016 dout  out  WORD_WIDTH  read data, valid only with dvalid.
REQ-017 dvalid  out  1  one-cycle read-data strobe.
REQ-018 err  out  1  one-cycle out-of-range strobe.

Function
REQ-019 Bank select SHALL be addr mod BANKS; the in-bank index SHALL be addr / BANKS.
REQ-020 ready SHALL be high when the selected bank is idle or addr >= SIZE; it SHALL be independent of re/we.
REQ-021 A request SHALL be accepted on a rising edge where (re or we) and ready are both high.
REQ-022 When re and we are both high, the read SHALL win and the write SHALL be ignored.
REQ-023 A write accept SHALL update only the bytes whose mask bit is set, at the accept edge.
REQ-024 A read accept SHALL sample the array at the accept edge.
REQ-025 For a read accepted at edge N, dvalid SHALL be high with that data in the cycle after edge N+READ_LATENCY-1 (latency 1: the cycle immediately after accept).
REQ-026 An accepted read SHALL hold its bank busy for READ_LATENCY-1 cycles; an accepted write SHALL hold it busy for WRITE_LATENCY-1 cycles.
REQ-027 Each bank SHALL have its own busy counter, decrementing once per cycle down to 0 (idle).
REQ-028 Accepts to different banks on consecutive cycles SHALL be allowed; read responses SHALL return in accept order through a READ_LATENCY-deep valid/data pipeline.
REQ-029 A request with addr >= SIZE SHALL pulse err in the next cycle, SHALL not access the array, and SHALL not busy any bank.
REQ-030 While dvalid is low, dout SHALL hold its last value.

Reset
REQ-031 While rst is high, all bank counters SHALL be 0, the response pipeline SHALL be cleared, and dvalid, err and dout SHALL be 0.
REQ-032 Reads in flight at reset SHALL be discarded and produce no dvalid.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 re and we SHALL be ignored in any cycle where rst is high.

Structure
REQ-035 The shared package SHALL hold the bank-index and counter-width derivation functions (clog2-based).
REQ-036 One sub-module, ram_bank, SHALL hold one bank's array, masked write and busy counter; banked_ram SHALL instantiate BANKS of them plus the response pipeline and decode logic.

Verification
Bench parameters: BANKS=4, WORD_WIDTH=32, SIZE=1024, READ_LATENCY=3, WRITE_LATENCY=2.
REQ-037 Write addr 0x10, data 0xDEADBEEF, mask 0xF -> ready low for the next cycle, then high. A read of 0x10 is then accepted, and dvalid pulses in the 3rd cycle after accept with dout=0xDEADBEEF.
REQ-038 Write 0x00001234 with mask 0x3 over 0xDEADBEEF at 0x10 -> a read of 0x10 returns 0xDEAD1234.
REQ-039 Reads of addr 0,1,2,3 on four consecutive cycles -> all four accepted; dvalid high on four consecutive cycles with data in order 0,1,2,3.
REQ-040 Read addr 0, then read addr 4 the next cycle (same bank) -> ready low for addr 4 for two cycles, accepted on the third.
REQ-041 Read addr 1024 -> err pulses one cycle later, ready stays high, no dvalid.
REQ-042 Read accepted, rst asserted one cycle later -> no dvalid ever appears; after reset, ready=1 and dvalid=err=dout=0.
